// File: rtl/cursor_controller_pkg.sv
// ---------------------------------------------------------------------------
// cursor_controller_pkg
//   Shared definitions for the pushbutton cursor path: default board size and
//   debounce length, the controller state encoding, and the wrap-around step
//   helper used for both pointer axes.
//   No ports (package).
// ---------------------------------------------------------------------------
package cursor_controller_pkg;

    localparam int DEFAULT_BOARD_WIDTH     = 15;
    localparam int DEFAULT_BOARD_HEIGHT    = 15;
    // 10 ms of stable input at 50 MHz
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_LOCKED = 2'd2
    } cursor_state_t;

    // One step along an axis of length 'limit'. Opposing requests cancel.
    // The edges are compared against limit-1 and 0 explicitly so that boards
    // whose size is not a power of two still wrap at the right place.
    function automatic int wrap_step(input int pos, input int limit,
                                     input logic step_inc, input logic step_dec);
        int next_pos;
        next_pos = pos;
        if (step_inc && !step_dec) begin
            next_pos = (pos == limit - 1) ? 0 : pos + 1;
        end else if (step_dec && !step_inc) begin
            next_pos = (pos == 0) ? limit - 1 : pos - 1;
        end
        return next_pos;
    endfunction

endpackage

// File: rtl/cursor_controller_key_debouncer.sv
// ---------------------------------------------------------------------------
// key_debouncer
//   Cleans up one raw, active-low pushbutton and emits a single-cycle pulse
//   each time the key settles into the pressed state.
//   Ports:
//     Clck         in   system clock
//     Reset        in   asynchronous, active-low reset
//     key_n        in   raw pushbutton, 0 = pressed, asynchronous to Clck
//     press_pulse  out  registered 1-cycle pulse on a stable press
// ---------------------------------------------------------------------------
module key_debouncer
    import cursor_controller_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic Clck,
    input  logic Reset,
    input  logic key_n,
    output logic press_pulse
);

    localparam int CNT_BITS = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic                sync_meta;
    logic                sync_pressed;
    logic                stable_pressed;
    logic                stable_prev;
    logic [CNT_BITS-1:0] count;

    // Two-flop synchronizer. The key is inverted on the way in so everything
    // downstream works in "pressed = 1" terms; reset means released.
    always_ff @(posedge Clck or negedge Reset) begin
        if (!Reset) begin
            sync_meta    <= 1'b0;
            sync_pressed <= 1'b0;
        end else begin
            sync_meta    <= ~key_n;
            sync_pressed <= sync_meta;
        end
    end

    // Count consecutive samples that disagree with the accepted state. Any
    // sample that agrees again throws the run away, so a short bounce never
    // reaches the end. When the run is long enough the accepted state flips.
    always_ff @(posedge Clck or negedge Reset) begin
        if (!Reset) begin
            count          <= '0;
            stable_pressed <= 1'b0;
        end else if (sync_pressed != stable_pressed) begin
            if (count == CNT_BITS'(DEBOUNCE_CYCLES - 1)) begin
                stable_pressed <= sync_pressed;
                count          <= '0;
            end else begin
                count <= count + CNT_BITS'(1);
            end
        end else begin
            count <= '0;
        end
    end

    // Edge detect on the accepted state: only released->pressed makes a
    // pulse, so a held key gives one pulse and a release gives none.
    always_ff @(posedge Clck or negedge Reset) begin
        if (!Reset) begin
            stable_prev <= 1'b0;
            press_pulse <= 1'b0;
        end else begin
            stable_prev <= stable_pressed;
            press_pulse <= stable_pressed & ~stable_prev;
        end
    end

endmodule

// File: rtl/cursor_controller.sv
// ---------------------------------------------------------------------------
// cursor_controller
//   Turns the five board pushbuttons into a wrap-around board cursor and a
//   placement request toward the game-rule block (req/ack handshake). All
//   input is locked out while the game is over.
//   Ports:
//     Clck           in   system clock, 50 MHz
//     Reset          in   asynchronous, active-low reset
//     key_up/down/left/right/place  in  raw pushbuttons, active-low
//     game_over      in   high while the game is finished
//     place_ack      in   1-cycle pulse: pending placement consumed
//     pointer_loc_x  out  cursor column
//     pointer_loc_y  out  cursor row
//     place_req      out  placement request pending
//     place_x        out  column of the pending placement
//     place_y        out  row of the pending placement
// ---------------------------------------------------------------------------
module cursor_controller
    import cursor_controller_pkg::*;
#(
    parameter int BOARD_WIDTH     = DEFAULT_BOARD_WIDTH,
    parameter int BOARD_HEIGHT    = DEFAULT_BOARD_HEIGHT,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic                            Clck,
    input  logic                            Reset,
    input  logic                            key_up,
    input  logic                            key_down,
    input  logic                            key_left,
    input  logic                            key_right,
    input  logic                            key_place,
    input  logic                            game_over,
    input  logic                            place_ack,
    output logic [$clog2(BOARD_WIDTH)-1:0]  pointer_loc_x,
    output logic [$clog2(BOARD_HEIGHT)-1:0] pointer_loc_y,
    output logic                            place_req,
    output logic [$clog2(BOARD_WIDTH)-1:0]  place_x,
    output logic [$clog2(BOARD_HEIGHT)-1:0] place_y
);

    localparam int X_BITS = $clog2(BOARD_WIDTH);
    localparam int Y_BITS = $clog2(BOARD_HEIGHT);

    cursor_state_t state;

    logic press_up;
    logic press_down;
    logic press_left;
    logic press_right;
    logic press_place;

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
        .Clck(Clck), .Reset(Reset), .key_n(key_up), .press_pulse(press_up)
    );

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_down (
        .Clck(Clck), .Reset(Reset), .key_n(key_down), .press_pulse(press_down)
    );

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_left (
        .Clck(Clck), .Reset(Reset), .key_n(key_left), .press_pulse(press_left)
    );

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_right (
        .Clck(Clck), .Reset(Reset), .key_n(key_right), .press_pulse(press_right)
    );

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_place (
        .Clck(Clck), .Reset(Reset), .key_n(key_place), .press_pulse(press_place)
    );

    // Controller FSM with the pointer and request outputs held directly in
    // its registers. game_over wins over any key pulse in every state; a
    // place pulse in IDLE swallows any move pulses of the same cycle so the
    // latched coordinates are exactly what the player saw. Leaving LOCKED
    // keeps the pointer where it was.
    always_ff @(posedge Clck or negedge Reset) begin
        if (!Reset) begin
            state         <= ST_IDLE;
            pointer_loc_x <= X_BITS'(BOARD_WIDTH / 2);
            pointer_loc_y <= Y_BITS'(BOARD_HEIGHT / 2);
            place_req     <= 1'b0;
            place_x       <= '0;
            place_y       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (game_over) begin
                        state <= ST_LOCKED;
                    end else if (press_place) begin
                        place_x   <= pointer_loc_x;
                        place_y   <= pointer_loc_y;
                        place_req <= 1'b1;
                        state     <= ST_REQ;
                    end else begin
                        pointer_loc_x <= X_BITS'(wrap_step(int'(pointer_loc_x), BOARD_WIDTH,
                                                           press_right, press_left));
                        pointer_loc_y <= Y_BITS'(wrap_step(int'(pointer_loc_y), BOARD_HEIGHT,
                                                           press_down, press_up));
                    end
                end
                ST_REQ: begin
                    if (game_over) begin
                        place_req <= 1'b0;
                        state     <= ST_LOCKED;
                    end else if (place_ack) begin
                        place_req <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                ST_LOCKED: begin
                    place_req <= 1'b0;
                    if (!game_over) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    place_req <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cursor_controller.sv
// ---------------------------------------------------------------------------
// tb_cursor_controller
//   Self-checking bench for cursor_controller with a short debounce window.
//   Directed scenarios cover latency, bounce rejection, wrap-around, the
//   placement handshake, game-over lockout and asynchronous reset; a random
//   phase then drives key operations against a behavioural board model.
// ---------------------------------------------------------------------------
module tb_cursor_controller;

    localparam int W = 15;
    localparam int H = 15;
    localparam int D = 4;

    localparam int K_UP    = 0;
    localparam int K_DOWN  = 1;
    localparam int K_LEFT  = 2;
    localparam int K_RIGHT = 3;
    localparam int K_PLACE = 4;

    logic       Clck = 1'b0;
    logic       Reset = 1'b0;
    logic [4:0] key_pressed = 5'b0;
    logic       game_over = 1'b0;
    logic       place_ack = 1'b0;

    logic       key_up, key_down, key_left, key_right, key_place;
    logic [3:0] pointer_loc_x, pointer_loc_y, place_x, place_y;
    logic       place_req;

    assign key_up    = ~key_pressed[K_UP];
    assign key_down  = ~key_pressed[K_DOWN];
    assign key_left  = ~key_pressed[K_LEFT];
    assign key_right = ~key_pressed[K_RIGHT];
    assign key_place = ~key_pressed[K_PLACE];

    int total = 0;
    int bad   = 0;

    // Behavioural board model
    int mx, my, mpx, mpy;
    bit mreq, mgo;

    cursor_controller #(
        .BOARD_WIDTH(W), .BOARD_HEIGHT(H), .DEBOUNCE_CYCLES(D)
    ) dut (
        .Clck(Clck), .Reset(Reset),
        .key_up(key_up), .key_down(key_down), .key_left(key_left),
        .key_right(key_right), .key_place(key_place),
        .game_over(game_over), .place_ack(place_ack),
        .pointer_loc_x(pointer_loc_x), .pointer_loc_y(pointer_loc_y),
        .place_req(place_req), .place_x(place_x), .place_y(place_y)
    );

    always #5 Clck = ~Clck;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        total++;
        if (observed != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic compareModel(input string tag);
        checkOutput({tag, ".x"}, int'(pointer_loc_x), mx);
        checkOutput({tag, ".y"}, int'(pointer_loc_y), my);
        checkOutput({tag, ".req"}, int'(place_req), int'(mreq));
        checkOutput({tag, ".px"}, int'(place_x), mpx);
        checkOutput({tag, ".py"}, int'(place_y), mpy);
    endtask

    function automatic void modelReset();
        mx = W / 2;
        my = H / 2;
        mpx = 0;
        mpy = 0;
        mreq = 1'b0;
    endfunction

    // What one accepted press of a key set does to the board
    function automatic void modelPress(input logic [4:0] k);
        if (mgo || mreq) return;
        if (k[K_PLACE]) begin
            mpx = mx;
            mpy = my;
            mreq = 1'b1;
        end else begin
            mx = (mx + int'(k[K_RIGHT]) - int'(k[K_LEFT]) + W) % W;
            my = (my + int'(k[K_DOWN]) - int'(k[K_UP]) + H) % H;
        end
    endfunction

    // Hold a key set low for 'hold' samples, release, and let it settle
    task automatic applyStimulus(input logic [4:0] keys, input int hold);
        @(negedge Clck);
        key_pressed = keys;
        repeat (hold) @(negedge Clck);
        key_pressed = 5'b0;
        repeat (D + 6) @(negedge Clck);
        if (hold >= D) modelPress(keys);
    endtask

    task automatic pressKeys(input logic [4:0] keys);
        applyStimulus(keys, D + 1);
    endtask

    task automatic pulseAck();
        @(negedge Clck);
        place_ack = 1'b1;
        @(negedge Clck);
        place_ack = 1'b0;
        if (mreq && !mgo) mreq = 1'b0;
        checkOutput("ack_next_edge.req", int'(place_req), int'(mreq));
        repeat (2) @(negedge Clck);
    endtask

    task automatic setGameOver(input logic v);
        @(negedge Clck);
        game_over = v;
        @(negedge Clck);
        if (v) mreq = 1'b0;
        mgo = v;
        checkOutput("game_over_edge.req", int'(place_req), int'(mreq));
        repeat (2) @(negedge Clck);
    endtask

    initial begin
        logic [4:0] k;
        int op;
        int guard;

        mgo = 1'b0;
        modelReset();

        // Reset state, observed while reset is still held
        repeat (3) @(negedge Clck);
        compareModel("reset");
        Reset = 1'b1;
        repeat (3) @(negedge Clck);
        compareModel("after_reset");

        // Clean right press: exact latency, then hold without repeat
        key_pressed = 5'b1 << K_RIGHT;
        for (int e = 0; e <= 7; e++) begin
            @(posedge Clck);
            @(negedge Clck);
            if (e == 0) checkOutput("latency_e0.x", int'(pointer_loc_x), 7);
            if (e == 6) checkOutput("latency_e6.x", int'(pointer_loc_x), 7);
            if (e == 7) begin
                checkOutput("latency_e7.x", int'(pointer_loc_x), 8);
                checkOutput("latency_e7.y", int'(pointer_loc_y), 7);
            end
        end
        mx = 8;
        repeat (20) @(negedge Clck);
        checkOutput("held_no_repeat.x", int'(pointer_loc_x), 8);
        key_pressed = 5'b0;
        repeat (D + 6) @(negedge Clck);

        // Bounce shorter than the window is rejected
        applyStimulus(5'b1 << K_LEFT, D - 1);
        compareModel("glitch");

        // Wrap-around on both axes
        repeat (6) pressKeys(5'b1 << K_RIGHT);
        checkOutput("reach14.x", int'(pointer_loc_x), 14);
        pressKeys(5'b1 << K_RIGHT);
        checkOutput("wrap_right.x", int'(pointer_loc_x), 0);
        repeat (7) pressKeys(5'b1 << K_UP);
        checkOutput("reach0.y", int'(pointer_loc_y), 0);
        pressKeys(5'b1 << K_UP);
        checkOutput("wrap_up.y", int'(pointer_loc_y), 14);
        pressKeys((5'b1 << K_UP) | (5'b1 << K_DOWN));
        checkOutput("up_down_cancel.y", int'(pointer_loc_y), 14);
        pressKeys(5'b1 << K_LEFT);
        checkOutput("wrap_left.x", int'(pointer_loc_x), 14);
        pressKeys(5'b1 << K_DOWN);
        checkOutput("wrap_down.y", int'(pointer_loc_y), 0);
        pressKeys((5'b1 << K_RIGHT) | (5'b1 << K_DOWN));
        checkOutput("diagonal.x", int'(pointer_loc_x), 0);
        checkOutput("diagonal.y", int'(pointer_loc_y), 1);
        compareModel("after_wraps");

        // Walk to (3,5) and place
        guard = 0;
        while (mx != 3 && guard < 20) begin pressKeys(5'b1 << K_RIGHT); guard++; end
        guard = 0;
        while (my != 5 && guard < 20) begin pressKeys(5'b1 << K_DOWN); guard++; end
        compareModel("at_3_5");
        pressKeys(5'b1 << K_PLACE);
        checkOutput("place.req", int'(place_req), 1);
        checkOutput("place.px", int'(place_x), 3);
        checkOutput("place.py", int'(place_y), 5);
        pressKeys(5'b1 << K_RIGHT);
        checkOutput("frozen.x", int'(pointer_loc_x), 3);
        checkOutput("frozen.y", int'(pointer_loc_y), 5);
        checkOutput("frozen.req", int'(place_req), 1);
        pulseAck();
        pressKeys(5'b1 << K_RIGHT);
        checkOutput("resume.x", int'(pointer_loc_x), 4);
        compareModel("after_ack");

        // Game over while a request is pending
        pressKeys(5'b1 << K_PLACE);
        compareModel("place2");
        setGameOver(1'b1);
        pressKeys(5'b1 << K_RIGHT);
        pressKeys(5'b1 << K_PLACE);
        compareModel("locked");
        setGameOver(1'b0);
        pressKeys(5'b1 << K_LEFT);
        checkOutput("unlocked.x", int'(pointer_loc_x), 3);
        compareModel("unlocked");

        // Random operations against the model
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 9);
            if (op <= 4) begin
                k = 5'b1 << $urandom_range(0, 4);
                applyStimulus(k, D + $urandom_range(0, 5));
            end else if (op == 5) begin
                k = (5'b1 << $urandom_range(0, 4)) | (5'b1 << $urandom_range(0, 4));
                applyStimulus(k, D + $urandom_range(0, 3));
            end else if (op == 6) begin
                k = 5'b1 << $urandom_range(0, 4);
                applyStimulus(k, $urandom_range(1, D - 1));
            end else if (op == 7 || op == 8) begin
                pulseAck();
            end else begin
                setGameOver(~mgo);
            end
            compareModel("random");
        end
        if (mgo) setGameOver(1'b0);

        // Asynchronous reset in the middle of a request
        if (!mreq) pressKeys(5'b1 << K_PLACE);
        compareModel("pre_reset_req");
        @(negedge Clck);
        key_pressed = 5'b1 << K_RIGHT;
        repeat (2) @(negedge Clck);
        #2;
        Reset = 1'b0;
        key_pressed = 5'b0;
        #1;
        modelReset();
        checkOutput("async_reset.req", int'(place_req), 0);
        checkOutput("async_reset.x", int'(pointer_loc_x), 7);
        checkOutput("async_reset.y", int'(pointer_loc_y), 7);
        @(negedge Clck);
        Reset = 1'b1;
        repeat (20) @(negedge Clck);
        compareModel("post_reset_no_pulse");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
